// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: F1 start-lights reaction game with prescaled light sequencer,
// LFSR random delay, reaction-time measurement, false-start detection and an
// optional best-time register (enabled by defining F1_BEST_TIME_EN).
module f1_reaction_timer #(
  parameter int unsigned NUM_LIGHTS = 8,
  parameter int unsigned N_WIDTH    = 5,
  parameter int unsigned K_WIDTH    = 7,
  parameter logic [K_WIDTH-1:0] LFSR_TAPS = 7'b1100000,
  parameter int unsigned RT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_WIDTH-1:0]    N,
  input  logic                  trigger,
  output logic [NUM_LIGHTS-1:0] data_out,
  output logic                  cmd_seq,
  output logic                  cmd_delay,
  output logic [RT_WIDTH-1:0]   rt_value,
  output logic                  rt_valid,
  output logic                  false_start,
  output logic [RT_WIDTH-1:0]   best_rt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEQ    = 2'd1,
    DELAY  = 2'd2,
    TIMING = 2'd3
  } state_t;

  localparam logic [NUM_LIGHTS-1:0] ALL_ON = '1;
  localparam logic [RT_WIDTH-1:0]   RT_MAX = '1;

  state_t                state_q, state_d;
  logic                  trigger_q;
  logic                  trig_edge;
  logic                  tick;
  logic [K_WIDTH-1:0]    lfsr_q;
  logic [N_WIDTH-1:0]    presc_q, presc_d;
  logic [K_WIDTH-1:0]    delay_q, delay_d;
  logic [RT_WIDTH-1:0]   rt_cnt_q, rt_cnt_d;
  logic [NUM_LIGHTS-1:0] data_d;
  logic [NUM_LIGHTS-1:0] data_shift;
  logic [RT_WIDTH-1:0]   rt_value_d;
  logic                  rt_valid_d;
  logic                  false_start_d;
  logic                  cmd_seq_d, cmd_delay_d;
  logic [RT_WIDTH-1:0]   best_q, best_d;

  assign trig_edge  = trigger & ~trigger_q;
  assign tick       = (presc_q == '0) && ((state_q == SEQ) || (state_q == DELAY));
  assign data_shift = {data_out[NUM_LIGHTS-2:0], 1'b1};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a trigger edge during SEQ/DELAY beats a coincident tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trig_edge) state_d = SEQ;
      SEQ:     if (trig_edge) state_d = IDLE;
               else if (tick && (data_shift == ALL_ON)) state_d = DELAY;
      DELAY:   if (trig_edge) state_d = IDLE;
               else if (tick && (delay_q == K_WIDTH'(1))) state_d = TIMING;
      TIMING:  if (trig_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    presc_d       = presc_q;
    delay_d       = delay_q;
    rt_cnt_d      = rt_cnt_q;
    data_d        = data_out;
    rt_value_d    = rt_value;
    rt_valid_d    = 1'b0;
    false_start_d = false_start;
    best_d        = best_q;

    if ((state_q == SEQ) || (state_q == DELAY)) begin
      presc_d = tick ? N : presc_q - N_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (trig_edge) begin
          data_d        = '0;
          false_start_d = 1'b0;
        end
      end
      SEQ: begin
        if (trig_edge) begin
          false_start_d = 1'b1;
          data_d        = '0;
        end else if (tick) begin
          data_d = data_shift;
          if (data_shift == ALL_ON) delay_d = lfsr_q;
        end
      end
      DELAY: begin
        if (trig_edge) begin
          false_start_d = 1'b1;
          data_d        = '0;
        end else if (tick) begin
          delay_d = delay_q - K_WIDTH'(1);
          if (delay_q == K_WIDTH'(1)) begin
            data_d   = '0;
            rt_cnt_d = '0;
          end
        end
      end
      TIMING: begin
        rt_cnt_d = (rt_cnt_q != RT_MAX) ? rt_cnt_q + RT_WIDTH'(1) : rt_cnt_q;
        if (trig_edge) begin
          rt_value_d = rt_cnt_q;
          rt_valid_d = 1'b1;
          if (rt_cnt_q < best_q) best_d = rt_cnt_q;
        end
      end
      default: ;
    endcase

    // Prescaler restarts a full period whenever SEQ or DELAY is entered
    if ((state_d != state_q) && ((state_d == SEQ) || (state_d == DELAY))) begin
      presc_d = N;
    end

    cmd_seq_d   = (state_d == SEQ);
    cmd_delay_d = (state_d == DELAY);
  end

  // Datapath registers; LFSR free-runs and can never reach zero from seed 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_q   <= 1'b0;
      lfsr_q      <= K_WIDTH'(1);
      presc_q     <= '0;
      delay_q     <= '0;
      rt_cnt_q    <= '0;
      data_out    <= '0;
      cmd_seq     <= 1'b0;
      cmd_delay   <= 1'b0;
      rt_value    <= '0;
      rt_valid    <= 1'b0;
      false_start <= 1'b0;
    end else begin
      trigger_q   <= trigger;
      lfsr_q      <= {lfsr_q[K_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
      presc_q     <= presc_d;
      delay_q     <= delay_d;
      rt_cnt_q    <= rt_cnt_d;
      data_out    <= data_d;
      cmd_seq     <= cmd_seq_d;
      cmd_delay   <= cmd_delay_d;
      rt_value    <= rt_value_d;
      rt_valid    <= rt_valid_d;
      false_start <= false_start_d;
    end
  end

`ifdef F1_BEST_TIME_EN
  // Best (smallest) reaction time since reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) best_q <= RT_MAX;
    else        best_q <= best_d;
  end
  assign best_rt = best_q;
`else
  assign best_q  = RT_MAX;
  assign best_rt = RT_MAX;
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer: vector table for sequencing and false
// start, hand-written runs for delay length, measurement, saturation and reset.
module tb_f1_reaction_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  n_in = '0;
  logic        trigger = 1'b0;

  logic [7:0]  data_out0;
  logic        cmd_seq0, cmd_delay0, rt_valid0, false_start0;
  logic [15:0] rt_value0, best_rt0;

  logic [7:0]  data_out1;
  logic        cmd_seq1, cmd_delay1, rt_valid1, false_start1;
  logic [3:0]  rt_value1, best_rt1;

  int errors = 0;
  int checks = 0;

  logic [6:0]  m_lfsr, m_prev;
  localparam logic [6:0] TAPS = 7'b1100000;

  logic [15:0] bb0;
  logic [3:0]  bb1;

  always #5 clk = ~clk;

  f1_reaction_timer dut0 (
    .clk(clk), .rst_n(rst_n), .N(n_in), .trigger(trigger),
    .data_out(data_out0), .cmd_seq(cmd_seq0), .cmd_delay(cmd_delay0),
    .rt_value(rt_value0), .rt_valid(rt_valid0), .false_start(false_start0),
    .best_rt(best_rt0)
  );

  f1_reaction_timer #(.RT_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .N(n_in), .trigger(trigger),
    .data_out(data_out1), .cmd_seq(cmd_seq1), .cmd_delay(cmd_delay1),
    .rt_value(rt_value1), .rt_valid(rt_valid1), .false_start(false_start1),
    .best_rt(best_rt1)
  );

  // Reference LFSR; m_prev is the value the DUT saw during the previous cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 7'd1;
      m_prev <= 7'd1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[5:0], ^(m_lfsr & TAPS)};
    end
  end

  typedef struct {
    logic       trig;
    logic [7:0] data;
    logic       seq;
    logic       dly;
    logic       fs;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start from IDLE, follow SEQ until DELAY, return the captured LFSR delay
  task automatic start_and_seq(input int n, output int l);
    int  scnt;
    bit  done;
    n_in = 5'(n);
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    check("seq_start_cmd", {31'd0, cmd_seq0}, 32'd1);
    check("seq_start_data", {24'd0, data_out0}, 32'd0);
    check("seq_start_fs", {31'd0, false_start0}, 32'd0);
    trigger = 1'b0;
    scnt = 1;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      if (cmd_seq0) scnt++;
      else done = 1'b1;
    end
    check("seq_len", 32'(scnt), 32'(8 * (n + 1)));
    check("delay_entry_cmd", {31'd0, cmd_delay0}, 32'd1);
    check("delay_entry_data", {24'd0, data_out0}, 32'hFF);
    l = int'(m_prev);
  endtask

  // From first DELAY cycle: check delay length, then press after 'press' cycles
  task automatic delay_and_press(input int n, input int l, input int press);
    int  dcnt;
    bit  done;
    int  exp1;
    trigger = 1'b0;
    dcnt = 1;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      if (cmd_delay0) dcnt++;
      else done = 1'b1;
    end
    check("delay_len", 32'(dcnt), 32'(l * (n + 1)));
    check("lights_out", {24'd0, data_out0}, 32'd0);
    check("timing_cmds", {30'd0, cmd_seq0, cmd_delay0}, 32'd0);
    repeat (press) step();
    trigger = 1'b1;
    step();
    exp1 = (press > 15) ? 15 : press;
`ifdef F1_BEST_TIME_EN
    if (16'(press) < bb0) bb0 = 16'(press);
    if (4'(exp1) < bb1) bb1 = 4'(exp1);
`endif
    check("rt_value", {16'd0, rt_value0}, 32'(press));
    check("rt_valid", {31'd0, rt_valid0}, 32'd1);
    check("rt_value_w4", {28'd0, rt_value1}, 32'(exp1));
    check("best_rt", {16'd0, best_rt0}, {16'd0, bb0});
    check("best_rt_w4", {28'd0, best_rt1}, {28'd0, bb1});
    step();
    check("rt_valid_pulse", {31'd0, rt_valid0}, 32'd0);
    check("held_no_refire", {31'd0, cmd_seq0}, 32'd0);
    check("rt_value_hold", {16'd0, rt_value0}, 32'(press));
    trigger = 1'b0;
  endtask

  initial begin
    int l;

    tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h07, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h07, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h1F, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h3F, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h7F, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};

    bb0 = '1;
    bb1 = '1;

    // Reset values
    rst_n = 1'b0;
    n_in = 5'd0;
    trigger = 1'b0;
    step();
    step();
    check("rst_data", {24'd0, data_out0}, 32'd0);
    check("rst_seq", {31'd0, cmd_seq0}, 32'd0);
    check("rst_delay", {31'd0, cmd_delay0}, 32'd0);
    check("rst_valid", {31'd0, rt_valid0}, 32'd0);
    check("rst_fs", {31'd0, false_start0}, 32'd0);
    check("rst_rt_value", {16'd0, rt_value0}, 32'd0);
    check("rst_best", {16'd0, best_rt0}, 32'hFFFF);
    check("rst_best_w4", {28'd0, best_rt1}, 32'hF);
    rst_n = 1'b1;
    step();

    // Vector table with N=0: false start at 0x07, restart, full light sequence
    for (int i = 0; i < 16; i++) begin
      trigger = tbl[i].trig;
      step();
      check($sformatf("tbl%0d_data", i), {24'd0, data_out0}, {24'd0, tbl[i].data});
      check($sformatf("tbl%0d_seq", i), {31'd0, cmd_seq0}, {31'd0, tbl[i].seq});
      check($sformatf("tbl%0d_dly", i), {31'd0, cmd_delay0}, {31'd0, tbl[i].dly});
      check($sformatf("tbl%0d_fs", i), {31'd0, false_start0}, {31'd0, tbl[i].fs});
      check($sformatf("tbl%0d_valid", i), {31'd0, rt_valid0}, 32'd0);
    end
    l = int'(m_prev);
    delay_and_press(0, l, 25);

    // Second run, slower reaction; best time unchanged
    start_and_seq(0, l);
    delay_and_press(0, l, 40);

    // N=3: four clocks per light step and per delay count
    start_and_seq(3, l);
    delay_and_press(3, l, 20);

    // Asynchronous reset in the middle of DELAY
    start_and_seq(0, l);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    bb0 = '1;
    bb1 = '1;
    check("arst_data", {24'd0, data_out0}, 32'd0);
    check("arst_delay", {31'd0, cmd_delay0}, 32'd0);
    check("arst_seq", {31'd0, cmd_seq0}, 32'd0);
    check("arst_rt_value", {16'd0, rt_value0}, 32'd0);
    check("arst_fs", {31'd0, false_start0}, 32'd0);
    check("arst_best", {16'd0, best_rt0}, 32'hFFFF);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fresh sequence after reset; press in the first TIMING cycle measures 0
    start_and_seq(0, l);
    delay_and_press(0, l, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
